// File: rtl/sprite_renderer_n.sv
// Scanline sprite renderer: fetches one W x H bitmap row per line from a byte ROM
// and shifts it out as colour indices, with mirroring, 1/2/4x zoom and early-hstart capture.
module sprite_renderer_n #(
  parameter int XBITS = 4,
  parameter int YBITS = 4,
  parameter int BPP   = 1,
  localparam int BBITS = $clog2(((1 << XBITS) * BPP) / 8)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vstart,
  input  logic                   load,
  input  logic                   hstart,
  input  logic                   hmirror,
  input  logic                   vmirror,
  input  logic [1:0]             xscale,
  input  logic [1:0]             yscale,
  output logic [YBITS+BBITS-1:0] rom_addr,
  input  logic [7:0]             rom_bits,
  output logic [BPP-1:0]         gfx,
  output logic                   gfx_valid,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  localparam int W  = 1 << XBITS;
  localparam int H  = 1 << YBITS;
  localparam int B  = (W * BPP) / 8;
  localparam int RW = W * BPP;
  localparam int IW = $clog2(RW);
  localparam int KW = (BBITS > 0) ? BBITS : 1;
  localparam int AW = YBITS + BBITS;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_LOAD   = 3'd1,
    S_FETCH_SETUP = 3'd2,
    S_FETCH_DATA  = 3'd3,
    S_WAIT_HSTART = 3'd4,
    S_DRAW        = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [YBITS-1:0]  y_q;
  logic [1:0]        yrep_q;
  logic [KW-1:0]     k_q;
  logic [XBITS-1:0]  x_q;
  logic [1:0]        xrep_q;
  logic              hpend_q;
  logic [RW-1:0]     rowbuf_q;
  logic              hmir_q, vmir_q;
  logic [1:0]        xs_q, ys_q;

  logic [1:0]        xrep_max, yrep_max;
  logic              k_last, pix_last, frame_last, hpend_eff;
  logic [XBITS-1:0]  pix_idx;
  logic [IW-1:0]     bit_idx, byte_base;
  logic [YBITS-1:0]  row_sel;
  logic [AW-1:0]     addr_d;
  logic [BPP-1:0]    gfx_d;

  // Zoom code 3 is a 4x alias, so the repeat terminal value saturates at 3.
  function automatic logic [1:0] rep_max(input logic [1:0] s);
    case (s)
      2'd0:    rep_max = 2'd0;
      2'd1:    rep_max = 2'd1;
      default: rep_max = 2'd3;
    endcase
  endfunction

  assign xrep_max   = rep_max(xs_q);
  assign yrep_max   = rep_max(ys_q);
  assign k_last     = (k_q == KW'(B - 1));
  assign pix_last   = (x_q == XBITS'(W - 1)) && (xrep_q == xrep_max);
  assign frame_last = pix_last && (y_q == YBITS'(H - 1)) && (yrep_q == yrep_max);
  // An hstart arriving on the last fetch cycle must also count, or that line would stall.
  assign hpend_eff  = hpend_q | hstart;

  assign pix_idx   = hmir_q ? ~x_q : x_q;
  assign bit_idx   = IW'(pix_idx) * IW'(BPP);
  assign byte_base = IW'(k_q) << 3;
  assign row_sel   = vmir_q ? ~y_q : y_q;
  assign addr_d    = (AW'(row_sel) << BBITS) | AW'(k_q);
  assign gfx_d     = (state_q == S_DRAW) ? rowbuf_q[bit_idx +: BPP] : '0;

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // vstart, load and hstart are single-sided strobes: the renderer samples them only in
  // the state that waits for them and never back-pressures the source.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (vstart) state_d = S_WAIT_LOAD;
      S_WAIT_LOAD:   if (load)   state_d = S_FETCH_SETUP;
      S_FETCH_SETUP: state_d = S_FETCH_DATA;
      S_FETCH_DATA: begin
        if (!k_last)        state_d = S_FETCH_SETUP;
        else if (hpend_eff) state_d = S_DRAW;
        else                state_d = S_WAIT_HSTART;
      end
      S_WAIT_HSTART: if (hstart) state_d = S_DRAW;
      S_DRAW: begin
        if (pix_last) state_d = frame_last ? S_IDLE : S_WAIT_LOAD;
      end
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q       <= '0;
      yrep_q    <= '0;
      k_q       <= '0;
      x_q       <= '0;
      xrep_q    <= '0;
      hpend_q   <= 1'b0;
      rowbuf_q  <= '0;
      hmir_q    <= 1'b0;
      vmir_q    <= 1'b0;
      xs_q      <= '0;
      ys_q      <= '0;
      rom_addr  <= '0;
      gfx       <= '0;
      gfx_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      gfx       <= gfx_d;
      gfx_valid <= |gfx_d;
      done      <= (state_q == S_DRAW) && frame_last;
      case (state_q)
        S_IDLE: begin
          y_q    <= '0;
          yrep_q <= '0;
          if (vstart) begin
            hmir_q <= hmirror;
            vmir_q <= vmirror;
            xs_q   <= xscale;
            ys_q   <= yscale;
          end
        end
        S_WAIT_LOAD: begin
          k_q     <= '0;
          x_q     <= '0;
          xrep_q  <= '0;
          hpend_q <= 1'b0;
        end
        S_FETCH_SETUP: begin
          rom_addr <= addr_d;
          if (hstart) hpend_q <= 1'b1;
        end
        S_FETCH_DATA: begin
          rowbuf_q[byte_base +: 8] <= rom_bits;
          if (hstart)  hpend_q <= 1'b1;
          if (!k_last) k_q <= k_q + 1'b1;
        end
        S_DRAW: begin
          if (xrep_q == xrep_max) begin
            xrep_q <= '0;
            x_q    <= x_q + 1'b1;
          end else begin
            xrep_q <= xrep_q + 1'b1;
          end
          // A finished line either repeats the same row (vertical zoom) or advances.
          if (pix_last) begin
            if (yrep_q == yrep_max) begin
              yrep_q <= '0;
              y_q    <= y_q + 1'b1;
            end else begin
              yrep_q <= yrep_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_renderer_n.sv
// Directed bench for sprite_renderer_n: a 16x16 1-bpp instance and an 8x4 2-bpp instance
// share line controls; each has its own ROM and its own vstart.
module tb_sprite_renderer_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       vstart_a, vstart_b, load, hstart, hmirror, vmirror;
  logic [1:0] xscale, yscale;

  logic [4:0] rom_addr_a;
  logic [7:0] rom_bits_a;
  logic [0:0] gfx_a;
  logic       gfx_valid_a, busy_a, done_a;
  logic [2:0] dbg_a;

  logic [2:0] rom_addr_b;
  logic [7:0] rom_bits_b;
  logic [1:0] gfx_b;
  logic       gfx_valid_b, busy_b, done_b;
  logic [2:0] dbg_b;

  logic [7:0] rom_a [32];
  logic [7:0] rom_b [8];
  assign rom_bits_a = rom_a[rom_addr_a];
  assign rom_bits_b = rom_b[rom_addr_b];

  sprite_renderer_n #(.XBITS(4), .YBITS(4), .BPP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .vstart(vstart_a), .load(load), .hstart(hstart),
    .hmirror(hmirror), .vmirror(vmirror), .xscale(xscale), .yscale(yscale),
    .rom_addr(rom_addr_a), .rom_bits(rom_bits_a), .gfx(gfx_a), .gfx_valid(gfx_valid_a),
    .busy(busy_a), .done(done_a), .dbg_state(dbg_a)
  );

  sprite_renderer_n #(.XBITS(3), .YBITS(2), .BPP(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .vstart(vstart_b), .load(load), .hstart(hstart),
    .hmirror(hmirror), .vmirror(vmirror), .xscale(xscale), .yscale(yscale),
    .rom_addr(rom_addr_b), .rom_bits(rom_bits_b), .gfx(gfx_b), .gfx_valid(gfx_valid_b),
    .busy(busy_b), .done(done_b), .dbg_state(dbg_b)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt_b = 0;

  always @(negedge clk) if (done_b) done_cnt_b <= done_cnt_b + 1;

  // Captured per line by run_line.
  logic [63:0] cap_addr, cap_pix, cap_val;
  logic        cap_pre, cap_done, cap_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vstart_a = 1'b0; vstart_b = 1'b0; load = 1'b0; hstart = 1'b0;
    hmirror = 1'b0; vmirror = 1'b0; xscale = 2'd0; yscale = 2'd0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_frame(input bit sel);
    if (sel) vstart_b = 1'b1;
    else     vstart_a = 1'b1;
    tick();
    vstart_a = 1'b0;
    vstart_b = 1'b0;
  endtask

  // One scanline: load, two byte fetches, then hstart (late, or early during the first fetch).
  task automatic run_line(input bit sel, input bit early, input int nsamp);
    cap_addr = '0; cap_pix = '0; cap_val = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    cap_addr[15:8] = sel ? 8'(rom_addr_b) : 8'(rom_addr_a);
    if (early) hstart = 1'b1;
    tick();
    hstart = 1'b0;
    tick();
    cap_addr[7:0] = sel ? 8'(rom_addr_b) : 8'(rom_addr_a);
    tick();
    if (!early) begin
      hstart = 1'b1;
      tick();
      hstart = 1'b0;
    end
    cap_pre = sel ? |gfx_b : gfx_a[0];
    tick();
    for (int i = 0; i < nsamp; i++) begin
      if (sel) cap_pix[i*2 +: 2] = gfx_b;
      else     cap_pix[i]        = gfx_a[0];
      cap_val[i] = sel ? gfx_valid_b : gfx_valid_a;
      if (i < nsamp - 1) tick();
    end
    cap_done = sel ? done_b : done_a;
    cap_busy = sel ? busy_b : busy_a;
  endtask

  // Expected 2x-horizontal-zoom line of the 2-bpp sprite: every pixel appears twice.
  function automatic logic [63:0] zoom_word_b(input int row);
    logic [63:0] w;
    logic [7:0]  bt;
    int          p;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      p  = j >> 1;
      bt = rom_b[row*2 + p/4];
      w[j*2 +: 2] = bt[(p%4)*2 +: 2];
    end
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom_a[i] = 8'(i * 37 + 11);
    rom_a[0]  = 8'h81; rom_a[1]  = 8'h07;
    rom_a[2]  = 8'h3C; rom_a[3]  = 8'hA5;
    rom_a[30] = 8'h35; rom_a[31] = 8'h00;
    rom_b[0] = 8'hE4; rom_b[1] = 8'h1B;
    rom_b[2] = 8'h55; rom_b[3] = 8'hAA;
    rom_b[4] = 8'h0F; rom_b[5] = 8'hF0;
    rom_b[6] = 8'h12; rom_b[7] = 8'h34;

    // Reset state
    do_reset();
    check("rst_rom_addr", 64'(rom_addr_a), 64'd0);
    check("rst_gfx", 64'(gfx_a), 64'd0);
    check("rst_gfx_valid", 64'(gfx_valid_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_state", 64'(dbg_a), 64'd0);

    // Plain row 0, then row 1 with controls changed after acceptance (must be ignored)
    start_frame(1'b0);
    check("accept_busy", 64'(busy_a), 64'd1);
    check("accept_state", 64'(dbg_a), 64'd1);
    hmirror = 1'b1; vmirror = 1'b1; xscale = 2'd2;
    run_line(1'b0, 1'b0, 16);
    check("l0_addr", cap_addr, 64'h0001);
    check("l0_pre", 64'(cap_pre), 64'd0);
    check("l0_pix", cap_pix, 64'h0781);
    check("l0_valid", cap_val, 64'h0781);
    check("l0_busy", 64'(cap_busy), 64'd1);
    check("l0_done", 64'(cap_done), 64'd0);
    tick();
    check("l0_gfx_after", 64'(gfx_a), 64'd0);
    run_line(1'b0, 1'b0, 16);
    check("l1_addr", cap_addr, 64'h0203);
    check("l1_pix_latched", cap_pix, 64'hA53C);

    // Both mirrors: first line reads row 15, pixels reversed
    do_reset();
    hmirror = 1'b1; vmirror = 1'b1;
    start_frame(1'b0);
    run_line(1'b0, 1'b0, 16);
    check("mir_addr", cap_addr, 64'h1E1F);
    check("mir_pix", cap_pix, 64'hAC00);

    // 2 bpp, W=8
    do_reset();
    start_frame(1'b1);
    run_line(1'b1, 1'b0, 8);
    check("bpp2_addr", cap_addr, 64'h0001);
    check("bpp2_pix", cap_pix, 64'h1BE4);
    check("bpp2_valid", cap_val, 64'h7E);

    // Zoom 2x horizontal, 4x vertical on the 4-row sprite: 16 lines, each row fetched 4 times
    do_reset();
    xscale = 2'd1; yscale = 2'd2;
    begin
      int d0;
      d0 = done_cnt_b;
      start_frame(1'b1);
      for (int l = 0; l < 16; l++) begin
        run_line(1'b1, 1'b0, 16);
        check($sformatf("zoom_addr_%0d", l), cap_addr, 64'((((l >> 2) * 2) << 8) | ((l >> 2) * 2 + 1)));
        check($sformatf("zoom_pix_%0d", l), cap_pix, zoom_word_b(l >> 2));
        check($sformatf("zoom_done_%0d", l), 64'(cap_done), 64'(l == 15));
        check($sformatf("zoom_busy_%0d", l), 64'(cap_busy), 64'(l != 15));
      end
      tick();
      check("zoom_done_after", 64'(done_b), 64'd0);
      check("zoom_busy_after", 64'(busy_b), 64'd0);
      check("zoom_done_count", 64'(done_cnt_b - d0), 64'd1);
    end

    // Early hstart during the first fetch: line starts right after the last fetch
    do_reset();
    start_frame(1'b0);
    run_line(1'b0, 1'b1, 16);
    check("early_addr", cap_addr, 64'h0001);
    check("early_pre", 64'(cap_pre), 64'd0);
    check("early_pix", cap_pix, 64'h0781);
    run_line(1'b0, 1'b0, 16);
    check("early_next_pix", cap_pix, 64'hA53C);

    // Asynchronous reset in the middle of a line, then a fresh frame with new controls
    do_reset();
    start_frame(1'b0);
    run_line(1'b0, 1'b0, 4);
    check("abort_partial_pix", cap_pix, 64'h1);
    check("abort_busy_before", 64'(busy_a), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_gfx", 64'(gfx_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_state", 64'(dbg_a), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("abort_gfx_after", 64'(gfx_a), 64'd0);
    hmirror = 1'b1;
    start_frame(1'b0);
    run_line(1'b0, 1'b0, 16);
    check("restart_addr", cap_addr, 64'h0001);
    check("restart_pix", cap_pix, 64'h81E0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
